// File: rtl/serial_pattern_source.sv
// Parallel-to-serial source for the bit-serial sequence detector's din input.
// Words arrive over valid/ready; a one-word holding buffer keeps back-to-back words gapless.
module serial_pattern_source #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    // state | meaning
    // IDLE  | no word in flight, dout_valid low
    // SHIFT | sreg bit selected by cnt is on dout this cycle
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign load_ready = !pend_full_q;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    sreg_d = shift_word(sreg_q);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (accept) begin
                        pend_d      = data_in;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    sreg_d      = pend_q;
                    pend_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // bypass the holding buffer when a word arrives on the last-bit edge
                    sreg_d = data_in;
                    cnt_d  = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        dout_valid_d = (state_d == SHIFT);
        dout_d       = dout_valid_d ? first_bit(sreg_d) : 1'b0;
        dout_last_d  = dout_valid_d && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = dout_valid_q | pend_full_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Scoreboard bench for serial_pattern_source: one MSB-first and one LSB-first instance.
// Accepts push expected {bit,last} pairs; a negedge monitor pops and compares.
module tb_serial_pattern_source;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] data_a = '0, data_b = '0;
    logic         lv_a = 1'b0, lv_b = 1'b0;
    logic         ready_a, dout_a, valid_a, last_a, busy_a;
    logic         ready_b, dout_b, valid_b, last_b, busy_b;

    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_a), .load_valid(lv_a),
        .load_ready(ready_a), .dout(dout_a), .dout_valid(valid_a),
        .dout_last(last_a), .busy(busy_a)
    );

    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(data_b), .load_valid(lv_b),
        .load_ready(ready_b), .dout(dout_b), .dout_valid(valid_b),
        .dout_last(last_b), .busy(busy_b)
    );

    int checks = 0;
    int failures = 0;

    logic [1:0]  q_a[$];
    logic [1:0]  q_b[$];
    logic [1:0]  e_a, e_b;
    logic        h_a, h_b;
    logic        acc_a, acc_b;
    int          runs[2], valid_cnt[2], last_cnt[2], ready_low[2];
    logic [63:0] cap[2];
    logic        prev_v[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int k, input logic v, input logic d, input logic l,
                            input logic r, input logic have, input logic [1:0] e);
        if (v) begin
            if (!prev_v[k]) runs[k]++;
            valid_cnt[k]++;
            cap[k] = {cap[k][62:0], d};
            if (l) last_cnt[k]++;
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_bit inst=%0d actual=%b required=none", k, {d, l});
            end else begin
                chk($sformatf("sb_bit_last inst=%0d", k), {62'b0, d, l}, {62'b0, e});
            end
        end else begin
            chk($sformatf("idle_outputs_zero inst=%0d", k), {62'b0, d, l}, 64'd0);
        end
        if (!r) ready_low[k]++;
        prev_v[k] = v;
    endtask

    // expected bit stream is queued on the edge that accepts the word
    always @(posedge clk) begin
        acc_a = reset && lv_a && ready_a;
        acc_b = reset && lv_b && ready_b;
        if (acc_a) for (int i = 0; i < W; i++) q_a.push_back({data_a[W-1-i], 1'(i == W - 1)});
        if (acc_b) for (int i = 0; i < W; i++) q_b.push_back({data_b[i], 1'(i == W - 1)});
    end

    always @(negedge clk) begin
        if (reset) begin
            h_a = valid_a && (q_a.size() > 0);
            e_a = 2'b00;
            if (h_a) e_a = q_a.pop_front();
            mon_step(0, valid_a, dout_a, last_a, ready_a, h_a, e_a);
            h_b = valid_b && (q_b.size() > 0);
            e_b = 2'b00;
            if (h_b) e_b = q_b.pop_front();
            mon_step(1, valid_b, dout_b, last_b, ready_b, h_b, e_b);
        end
    end

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            runs[k] = 0; valid_cnt[k] = 0; last_cnt[k] = 0; ready_low[k] = 0; cap[k] = '0;
        end
    endtask

    task automatic send(input int k, input logic [W-1:0] w);
        @(posedge clk); #1;
        if (k == 0) begin lv_a = 1'b1; data_a = w; end
        else        begin lv_b = 1'b1; data_b = w; end
        @(posedge clk); #1;
        lv_a = 1'b0;
        lv_b = 1'b0;
    endtask

    task automatic wait_idle(input int k, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k == 0) ? (busy_a | valid_a) : (busy_b | valid_b)) && n < 300);
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=busy required=idle", name);
        end
        #1;
    endtask

    task automatic check_outputs_reset(input string tag);
        chk({tag, "_dout"},       {63'b0, dout_a},  64'd0);
        chk({tag, "_dout_valid"}, {63'b0, valid_a}, 64'd0);
        chk({tag, "_dout_last"},  {63'b0, last_a},  64'd0);
        chk({tag, "_busy"},       {63'b0, busy_a},  64'd0);
        chk({tag, "_load_ready"}, {63'b0, ready_a}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_stats();
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;

        #6;
        check_outputs_reset("por");
        chk("por_lsb_valid", {63'b0, valid_b}, 64'd0);
        #6 reset = 1'b1;

        // single word, MSB first
        clear_stats();
        send(0, 8'hB2);
        wait_idle(0, "t1_idle");
        chk("t1_bits", cap[0][7:0], 64'h00000000000000B2);
        chk("t1_valid_cycles", valid_cnt[0], 8);
        chk("t1_runs", runs[0], 1);
        chk("t1_last_pulses", last_cnt[0], 1);
        chk("t1_busy_after", {63'b0, busy_a}, 64'd0);
        chk("t1_sb_drained", q_a.size(), 0);

        // back-to-back via the holding buffer
        clear_stats();
        @(posedge clk); #1;
        lv_a = 1'b1; data_a = 8'hB2;
        @(posedge clk); #1;
        data_a = 8'h4D;
        @(posedge clk); #1;
        lv_a = 1'b0;
        wait_idle(0, "t2_idle");
        chk("t2_bits", cap[0][15:0], 64'h000000000000B24D);
        chk("t2_valid_cycles", valid_cnt[0], 16);
        chk("t2_runs_no_gap", runs[0], 1);
        chk("t2_last_pulses", last_cnt[0], 2);
        chk("t2_ready_low_cycles", ready_low[0], 7);
        chk("t2_sb_drained", q_a.size(), 0);

        // bypass: next word offered only during the last bit
        clear_stats();
        send(0, 8'h00);
        n = 0;
        while (!last_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t3_saw_last", {63'b0, last_a}, 64'd1);
        lv_a = 1'b1; data_a = 8'hFF;
        @(posedge clk); #1;
        lv_a = 1'b0;
        wait_idle(0, "t3_idle");
        chk("t3_bits", cap[0][15:0], 64'h00000000000000FF);
        chk("t3_valid_cycles", valid_cnt[0], 16);
        chk("t3_runs_no_gap", runs[0], 1);
        chk("t3_sb_drained", q_a.size(), 0);

        // LSB first
        clear_stats();
        send(1, 8'hB2);
        wait_idle(1, "t4_idle");
        chk("t4_bits", cap[1][7:0], 64'h000000000000004D);
        chk("t4_valid_cycles", valid_cnt[1], 8);
        chk("t4_last_pulses", last_cnt[1], 1);
        chk("t4_sb_drained", q_b.size(), 0);

        // reset mid-frame with a word pending
        @(posedge clk); #1;
        lv_a = 1'b1; data_a = 8'hB2;
        @(posedge clk); #1;
        data_a = 8'h4D;
        @(posedge clk); #1;
        lv_a = 1'b0;
        chk("t5_pend_full", {63'b0, ready_a}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t5_valid_before_reset", {63'b0, valid_a}, 64'd1);
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
        #1;
        check_outputs_reset("t5_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        clear_stats();
        send(0, 8'h81);
        wait_idle(0, "t5_idle");
        chk("t5_bits", cap[0][7:0], 64'h0000000000000081);
        chk("t5_valid_cycles", valid_cnt[0], 8);
        chk("t5_runs", runs[0], 1);
        chk("t5_sb_drained", q_a.size(), 0);

        // continuous load_valid with incrementing data
        clear_stats();
        @(posedge clk); #1;
        lv_a = 1'b1; data_a = 8'h10;
        n = 0;
        for (int g = 0; g < 200 && n < 6; g++) begin
            @(posedge clk); #1;
            if (acc_a) begin
                n++;
                data_a = data_a + 8'd1;
            end
        end
        lv_a = 1'b0;
        chk("t6_words_accepted", n, 6);
        wait_idle(0, "t6_idle");
        chk("t6_bits", cap[0][47:0], 64'h0000101112131415);
        chk("t6_valid_cycles", valid_cnt[0], 48);
        chk("t6_runs_no_gap", runs[0], 1);
        chk("t6_last_pulses", last_cnt[0], 6);
        chk("t6_sb_drained", q_a.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_pattern_source.md
# serial_pattern_source

Parallel-to-serial stage that feeds the bit-serial sequence detector's `din` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `dout`. A one-entry holding buffer lets back-to-back words stream with no idle cycle between them. `dout` connects directly to the detector's `din`; `dout_valid` marks the cycles carrying real data.

## Interface
- `WIDTH`, 8: bits per word; minimum 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk`.
- `data_in`  in  WIDTH  word to serialize; sampled on an accept edge.
- `load_valid`  in  1  `data_in` is valid.
- `load_ready`  out  1  block can take a word; combinational, equals !`pend_full`.
- `dout`  out  1  serial bit, registered; 0 whenever `dout_valid`=0.
- `dout_valid`  out  1  `dout` carries a data bit this cycle; registered.
- `dout_last`  out  1  high on the final bit of a word; registered; only high when `dout_valid`=1.
- `busy`  out  1  `dout_valid` | `pend_full`.

## Operation
- **Accept:** an accept occurs on a rising edge where `load_valid`=1 and `load_ready`=1. `load_valid` may drop or change at any time; no data is taken without `load_ready`.
- **State:**
  - FSM states: IDLE and SHIFT.
  - `sreg` is a WIDTH-bit shift register.
  - `cnt` is a clog2(WIDTH)-bit bit index running 0..WIDTH-1.
  - `pend` is a WIDTH-bit holding register with full flag `pend_full`.
- **IDLE + accept:** load `sreg`, `cnt`=0, go to SHIFT. `pend` is untouched.
- **SHIFT + accept, cnt<WIDTH-1:** the word goes into `pend`; `pend_full`=1.
- **SHIFT, cnt<WIDTH-1:** output the next bit, `cnt`+1.
- **SHIFT, cnt=WIDTH-1 (last bit driven this cycle):**
  - `pend_full`=1: move `pend` into `sreg`, clear `pend_full`, `cnt`=0, stay in SHIFT.
  - `pend_full`=0 and an accept occurs on this edge: load `data_in` straight into `sreg` (bypass), `cnt`=0, stay in SHIFT.
  - Otherwise: go to IDLE.
- Accept with `pend_full`=1 is impossible because `load_ready`=0.
- **Bit order:**
  - `MSB_FIRST`=1: `dout` = `sreg`[WIDTH-1], shift left.
  - `MSB_FIRST`=0: `dout` = `sreg`[0], shift right.
- `dout_last`=1 exactly when SHIFT and `cnt`=WIDTH-1.
- **Reset values** (asserted or mid-frame):
  - IDLE, `cnt`=0, `sreg`=0, `pend`=0, `pend_full`=0.
  - `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `load_ready`=1.
  - A frame in progress is dropped with no partial completion. The first accept after release starts a fresh word at bit 0.

## Timing
- **Latency:** accept on edge E makes the first bit visible on `dout` in the cycle after E. The final bit is visible in cycle E+WIDTH, with `dout_last`=1.
- **One word:** `dout_valid` is high for exactly WIDTH consecutive cycles.
- **Back-to-back:** when the next word is accepted or pending before the last-bit edge, `dout_valid` stays high continuously with zero gap. Word N+1's first bit follows word N's last bit on the very next cycle.
- **Throughput:** one bit per clock. Sustained input rate is one word per WIDTH cycles.
- **`load_ready` timing:** low from the edge that fills `pend` until the last-bit edge of the current word, then high again in the next cycle.
- `dout`, `dout_valid` and `dout_last` change only on rising edges or asynchronously on reset assertion.

## Test plan
1. **Single word:** reset low for 12 ns, then release; accept 8'hB2 with `MSB_FIRST`=1 → `dout` = 1,0,1,1,0,0,1,0 over the 8 cycles after the accept. `dout_valid` is high for exactly those 8 cycles, `dout_last` is high only on the 8th, then IDLE with `busy`=0.
2. **Back-to-back:** hold `load_valid` with 8'hB2, then 8'h4D offered the cycle after the first accept → 16 contiguous valid bits 10110010 01001101. `load_ready` is low from the second accept until the first word's last bit. `dout_last` pulses at bits 8 and 16.
3. **Bypass on last bit:** offer 8'hFF only in the cycle where `dout_last`=1 of word 8'h00 → no gap; eight 0s then eight 1s contiguous.
4. **LSB-first:** `MSB_FIRST`=0, accept 8'hB2 → `dout` = 0,1,0,0,1,1,0,1.
5. **Reset mid-frame:** assert reset at bit 3 of 8'hB2 with a word pending → `dout`, `dout_valid` and `dout_last` go to 0 immediately; `load_ready`=1 and `busy`=0. After release, accept 8'h81 → exactly 1,0,0,0,0,0,0,1 with no residue from the earlier words.
6. **Backpressure:** keep `load_valid`=1 continuously with an incrementing counter value on `data_in` → each value appears serialized exactly once, in order, with no dropped or duplicated words.
